// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives IM, and buffers
// {pc, instr} pairs in a 2-entry queue for decode.
module ifu_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] im_addr,
  output logic        im_en,
  input  logic [31:0] im_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FAULT
  } state_e;

  // One bit wider so a window ending at 2^32 cannot overflow.
  localparam logic [32:0] PC_END =
    {1'b0, PC_RESET} + (33'(IM_DEPTH) << 2);

  state_e      state_q;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [31:0] qpc_q  [2];
  logic [31:0] qins_q [2];
  logic        fault_q;
  logic [31:0] fault_pc_q;
  logic [31:0] fetch_cnt_q;

  logic legal;
  logic run;
  logic flush;
  logic pop;
  logic fetch;
  logic trap;

  assign legal = (pc_q[1:0] == 2'b00)
              && (pc_q >= PC_RESET)
              && ({1'b0, pc_q} < PC_END);

  assign run   = (state_q == S_RUN);
  assign flush = redirect_valid && (state_q != S_IDLE);
  assign pop   = out_valid && out_ready;

  assign fetch = run && !redirect_valid && legal
              && ((cnt_q != 2'd2) || pop);
  assign trap  = run && !redirect_valid && !legal;

  assign im_addr   = pc_q;
  assign im_en     = fetch;
  assign out_valid = (cnt_q != 2'd0);
  assign out_pc    = qpc_q[head_q];
  assign out_instr = qins_q[head_q];
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
  assign fetch_cnt = fetch_cnt_q;

  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (1'b1)
      flush: begin
        pc_d   = redirect_target;
        cnt_d  = 2'd0;
        head_d = 1'b0;
        tail_d = 1'b0;
      end
      default: begin
        if (fetch) begin
          pc_d   = pc_q + 32'd4;
          tail_d = ~tail_q;
        end
        if (pop) begin
          head_d = ~head_q;
        end
        cnt_d = cnt_q + {1'b0, fetch} - {1'b0, pop};
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= PC_RESET;
      cnt_q       <= 2'd0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      fetch_cnt_q <= 32'd0;
      qpc_q[0]    <= 32'd0;
      qpc_q[1]    <= 32'd0;
      qins_q[0]   <= 32'd0;
      qins_q[1]   <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      if (fetch) begin
        qpc_q[tail_q]  <= pc_q;
        qins_q[tail_q] <= im_instr;
        fetch_cnt_q    <= fetch_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_RUN;
        end
        S_RUN: begin
          if (trap) begin
            state_q    <= S_FAULT;
            fault_q    <= 1'b1;
            fault_pc_q <= pc_q;
          end
        end
        S_FAULT: begin
          // fault_pc is kept as a record of the last trap.
          if (redirect_valid) begin
            state_q <= S_RUN;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] im_addr;
  logic        im_en;
  logic [31:0] im_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .im_addr(im_addr),
    .im_en(im_en),
    .im_instr(im_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .fault(fault),
    .fault_pc(fault_pc),
    .fetch_cnt(fetch_cnt)
  );

  function automatic logic [31:0] imem(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  assign im_instr = imem(im_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  int          mode;
  logic [31:0] m_pc;
  logic [31:0] m_fpc;
  logic [31:0] m_cnt;
  bit          m_fault;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  function automatic bit legal(logic [31:0] a);
    return (a % 4 == 0) && (a >= 32'h3000) && (a < 32'h7000);
  endfunction

  task automatic m_reset();
    q.delete();
    mode    = 0;
    m_pc    = 32'h3000;
    m_fpc   = 32'd0;
    m_cnt   = 32'd0;
    m_fault = 1'b0;
  endtask

  function automatic bit exp_en();
    bit can_pop;
    can_pop = (q.size() > 0) && out_ready;
    return (mode == 1) && !redirect_valid && legal(m_pc)
        && ((q.size() < 2) || can_pop);
  endfunction

  task automatic drive(bit st, bit rdy, bit rv, logic [31:0] rt);
    start           = st;
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = rt;
    #1;
    chk("im_addr", im_addr, m_pc);
    chk("im_en", 32'(im_en), 32'(exp_en()));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].ins);
    end
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_pc", fault_pc, m_fpc);
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic step();
    ent_t e;
    bit   pop;
    pop = (q.size() > 0) && out_ready;
    case (mode)
      0: if (start) mode = 1;
      1: begin
        if (redirect_valid) begin
          q.delete();
          m_pc = redirect_target;
        end else if (!legal(m_pc)) begin
          if (pop) q.delete(0);
          mode    = 2;
          m_fault = 1'b1;
          m_fpc   = m_pc;
        end else begin
          if (pop) q.delete(0);
          if (q.size() < 2) begin
            e.pc  = m_pc;
            e.ins = imem(m_pc);
            q.push_back(e);
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
          end
        end
      end
      default: begin
        if (redirect_valid) begin
          q.delete();
          m_pc    = redirect_target;
          mode    = 1;
          m_fault = 1'b0;
        end else if (pop) begin
          q.delete(0);
        end
      end
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(bit st, bit rdy, bit rv, logic [31:0] rt);
    drive(st, rdy, rv, rt);
    step();
  endtask

  task automatic areset();
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_im_addr", im_addr, 32'h3000);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] base;
    base = 32'h3000 + 4 * $urandom_range(0, 4095);
    case ($urandom_range(0, 5))
      0, 1: return base;
      2:    return base + $urandom_range(1, 3);
      3:    return 32'h6FF0 + 4 * $urandom_range(0, 3);
      4:    return 32'h2FFC;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset           = 1'b0;
    start           = 1'b0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    drive(0, 0, 0, 0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    step();

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("full_pc_hold", im_addr, 32'h3008);
    chk("full_im_en", 32'(im_en), 32'd0);
    chk("full_head", out_pc, 32'h3000);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      chk("drain_seq", out_pc, 32'h3000 + 32'(4 * i));
      step();
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h3100);
    drive(0, 1, 0, 0);
    chk("redir_bubble", 32'(out_valid), 32'd0);
    step();
    drive(0, 1, 0, 0);
    chk("redir_first", out_pc, 32'h3100);
    step();

    cyc(0, 1, 1, 32'h3102);
    cyc(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h3102);
    chk("mis_im_en", 32'(im_en), 32'd0);
    step();
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h3000);
    drive(0, 1, 0, 0);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("resume_pc", im_addr, 32'h3000);
    step();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);

    cyc(0, 1, 1, 32'h6FF8);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("last_word", out_pc, 32'h6FFC);
    step();
    drive(0, 1, 0, 0);
    chk("end_fault", 32'(fault), 32'd1);
    chk("end_fault_pc", fault_pc, 32'h7000);
    step();
    cyc(0, 0, 0, 0);
    areset();

    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) areset();
      cyc($urandom_range(0, 3) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0,
          rnd_tgt());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
